// File: rtl/mpmc11_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mpmc11_pkg : shared constants and types for the mpmc11 controller  rev 1.0 |
// +--------------------------------------------------------------------------+
package mpmc11_pkg;

  localparam int MPMC11_FIFO_RST_BUSY = 8;

  typedef enum logic [1:0] {
    FIFO_RESET = 2'd0,
    FIFO_WARM  = 2'd1,
    FIFO_RUN   = 2'd2
  } mpmc11_fifo_rst_state_t;

endpackage
`default_nettype wire

// File: rtl/mpmc11_fifo_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mpmc11_fifo_ram : 1W/1R array with registered, read-first output  rev 1.0 |
// +--------------------------------------------------------------------------+
module mpmc11_fifo_ram #(
  parameter int WID = 128,
  parameter int AW  = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           we,
  input  logic [AW-1:0]  waddr,
  input  logic [WID-1:0] wdata,
  input  logic           re,
  input  logic [AW-1:0]  raddr,
  output logic [WID-1:0] rdata
);

  logic [WID-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read-first: on a full-FIFO read+write to the same slot the old word is returned.
  always_ff @(posedge clk) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule
`default_nettype wire

// File: rtl/mpmc11_cmd_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mpmc11_cmd_fifo : synchronous command FIFO with reset-busy sequencer rev 1.0|
// +--------------------------------------------------------------------------+
module mpmc11_cmd_fifo
  import mpmc11_pkg::*;
#(
  parameter int WID          = 128,
  parameter int DEP          = 32,
  parameter int AFULL_MARGIN = 4,
  parameter int RST_BUSY     = MPMC11_FIFO_RST_BUSY
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr,
  input  logic [WID-1:0]         din,
  input  logic                   rd,
  output logic [WID-1:0]         dout,
  output logic                   valid,
  output logic                   empty,
  output logic                   full,
  output logic                   almost_full,
  output logic [$clog2(DEP):0]   count,
  output logic                   wr_rst_busy,
  output logic                   rd_rst_busy,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int          AW    = $clog2(DEP);
  localparam int          CW    = (RST_BUSY > 1) ? $clog2(RST_BUSY) : 1;
  localparam logic [AW:0] ONE   = (AW+1)'(1);
  localparam logic [AW:0] DEPC  = (AW+1)'(DEP);
  localparam logic [AW:0] AF_TH = (AW+1)'(DEP - AFULL_MARGIN);

  mpmc11_fifo_rst_state_t st;
  logic [CW-1:0]          warm_cnt;
  logic [AW:0]            wp, rp, wp_nx, rp_nx, cnt_nx;
  logic                   wa, ra;

  assign ra     = rd && !rd_rst_busy && !empty;
  assign wa     = wr && !wr_rst_busy && (!full || ra);
  assign wp_nx  = wa ? wp + ONE : wp;
  assign rp_nx  = ra ? rp + ONE : rp;
  assign cnt_nx = wp_nx - rp_nx;

  // Reset-busy sequencer: write side opens one cycle before the read side.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st          <= FIFO_RESET;
      warm_cnt    <= '0;
      wr_rst_busy <= 1'b1;
      rd_rst_busy <= 1'b1;
    end else begin
      case (st)
        FIFO_RESET: begin
          st       <= FIFO_WARM;
          warm_cnt <= CW'(RST_BUSY - 1);
        end
        FIFO_WARM: begin
          if (warm_cnt != '0) begin
            warm_cnt <= warm_cnt - CW'(1);
          end else if (wr_rst_busy) begin
            wr_rst_busy <= 1'b0;
          end else begin
            st          <= FIFO_RUN;
            rd_rst_busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Flags come from the next-state pointers so they track the pointers exactly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp          <= '0;
      rp          <= '0;
      count       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
      valid       <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      wp          <= wp_nx;
      rp          <= rp_nx;
      count       <= cnt_nx;
      empty       <= (cnt_nx == '0);
      full        <= (cnt_nx == DEPC);
      almost_full <= (cnt_nx >= AF_TH);
      valid       <= ra;
      overflow    <= wr && !wr_rst_busy && !wa;
      underflow   <= rd && !rd_rst_busy && !ra;
    end
  end

  mpmc11_fifo_ram #(
    .WID (WID),
    .AW  (AW)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wa),
    .waddr (wp[AW-1:0]),
    .wdata (din),
    .re    (ra),
    .raddr (rp[AW-1:0]),
    .rdata (dout)
  );

endmodule
`default_nettype wire

// File: tb/tb_mpmc11_cmd_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mpmc11_cmd_fifo : scoreboard bench for mpmc11_cmd_fifo          rev 1.0 |
// +--------------------------------------------------------------------------+
module tb_mpmc11_cmd_fifo;

  localparam int WID = 32;
  localparam int DEP = 32;
  localparam int AFM = 4;
  localparam int RSB = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 wr, rd;
  logic [WID-1:0]       din;
  logic [WID-1:0]       dout;
  logic                 valid, empty, full, almost_full;
  logic [$clog2(DEP):0] count;
  logic                 wr_rst_busy, rd_rst_busy, overflow, underflow;

  mpmc11_cmd_fifo #(
    .WID(WID), .DEP(DEP), .AFULL_MARGIN(AFM), .RST_BUSY(RSB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr(wr), .din(din), .rd(rd),
    .dout(dout), .valid(valid), .empty(empty), .full(full),
    .almost_full(almost_full), .count(count),
    .wr_rst_busy(wr_rst_busy), .rd_rst_busy(rd_rst_busy),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int             pass_cnt  = 0;
  int             total_cnt = 0;
  int             edge_k    = 0;   // rising edges since reset release
  logic [WID-1:0] model_q[$];      // words the FIFO should hold
  logic [WID-1:0] exp_q[$];        // read data awaiting presentation

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Monitor: every presented word must be the oldest outstanding expected read.
  always @(negedge clk) begin
    logic [WID-1:0] e;
    if (valid === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("rd_data", dout, e);
      end
    end
  end

  task automatic step(input bit w, input logic [WID-1:0] d, input bit r);
    bit wb, rb, ra_m, wa_m, ovf_m, udf_m;
    int n, k;
    wr = w; din = d; rd = r;
    k  = edge_k;
    n  = model_q.size();
    wb = (k <= RSB);
    rb = (k <= RSB + 1);
    ra_m  = r && !rb && (n > 0);
    wa_m  = w && !wb && ((n < DEP) || ra_m);
    ovf_m = w && !wb && !wa_m;
    udf_m = r && !rb && !ra_m;
    if (ra_m) exp_q.push_back(model_q.pop_front());
    if (wa_m) model_q.push_back(d);
    @(posedge clk);
    #1;
    edge_k++;
    n = model_q.size();
    chk("count",       count,       n);
    chk("empty",       empty,       n == 0);
    chk("full",        full,        n == DEP);
    chk("almost_full", almost_full, n >= DEP - AFM);
    chk("overflow",    overflow,    ovf_m);
    chk("underflow",   underflow,   udf_m);
    chk("valid",       valid,       ra_m);
    chk("wr_rst_busy", wr_rst_busy, k < RSB);
    chk("rd_rst_busy", rd_rst_busy, k < RSB + 1);
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0; wr = 1'b0; rd = 1'b0; din = '0;
    repeat (cycles) @(posedge clk);
    #1;
    model_q.delete();
    edge_k = 0;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full",  full, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_dout",  dout, 0);
    chk("rst_valid", valid, 0);
    chk("rst_ovf",   overflow, 0);
    chk("rst_udf",   underflow, 0);
    chk("rst_wbusy", wr_rst_busy, 1);
    chk("rst_rbusy", rd_rst_busy, 1);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; wr = 1'b0; rd = 1'b0; din = '0;
    do_reset(2);

    // Write held high through the busy window; read strobes too.
    for (int i = 0; i < RSB + 2; i++) step(1'b1, WID'(32'h100 + i), 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);

    // Fill 0x1..0x20 back-to-back, then drain.
    for (int i = 1; i <= DEP; i++) step(1'b1, WID'(i), 1'b0);
    for (int i = 0; i < DEP; i++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    // Full: dropped write, then simultaneous read+write.
    for (int i = 0; i < DEP; i++) step(1'b1, WID'(32'h200 + i), 1'b0);
    step(1'b1, WID'(32'hDEAD), 1'b0);
    step(1'b1, WID'(32'hBEEF), 1'b1);
    for (int i = 0; i < DEP; i++) step(1'b0, '0, 1'b1);

    // Empty: simultaneous read+write, then read the word back.
    step(1'b1, WID'(32'h55), 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    // Random interleaving across pointer wrap.
    for (int i = 0; i < 100; i++)
      step(1'($urandom_range(0, 1)), WID'($urandom), 1'($urandom_range(0, 1)));
    while (model_q.size() > 0) step(1'b0, '0, 1'b1);

    // Mid-operation reset with 10 words stored.
    for (int i = 0; i < 10; i++) step(1'b1, WID'(32'h300 + i), 1'b0);
    step(1'b0, '0, 1'b0);
    do_reset(1);
    for (int i = 0; i < RSB + 2; i++) step(1'b0, '0, 1'b1);
    step(1'b1, WID'(32'h77), 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);

    chk("pending_reads", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mpmc11_cmd_fifo.md
# mpmc11_cmd_fifo

Synchronous command FIFO for the mpmc11 controller. It buffers port request words and presents them to the controller core. It feeds the read-strobe generator, which issues a one-cycle `rd` while the core is in IDLE and this block reports `!empty && !rd_rst_busy`. Read data is standard-mode: a word appears on `dout` one cycle after an accepted `rd`, qualified by `valid`.

## Interface
Parameters:
- `WID`, 128: width of a command word in bits.
- `DEP`, 32: depth in words; must be a power of 2 and at least 4.
- `AFULL_MARGIN`, 4: `almost_full` asserts when `count >= DEP - AFULL_MARGIN`.
- `RST_BUSY`, `MPMC11_FIFO_RST_BUSY` (8): number of cycles after reset release before the FIFO accepts writes.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `wr`  in  1  write strobe.
- `din`  in  WID  write data.
- `rd`  in  1  read strobe.
- `dout`  out  WID  read data, registered.
- `valid`  out  1  `dout` was loaded this cycle by an accepted read.
- `empty`  out  1  no words stored.
- `full`  out  1  `DEP` words stored.
- `almost_full`  out  1  threshold flag set by `AFULL_MARGIN`.
- `count`  out  $clog2(DEP)+1  number of stored words.
- `wr_rst_busy`  out  1  writes are being ignored because of reset.
- `rd_rst_busy`  out  1  reads are being ignored because of reset.
- `overflow`  out  1  one-cycle pulse: a write was dropped because the FIFO was full.
- `underflow`  out  1  one-cycle pulse: a read was dropped because the FIFO was empty.

## Operation
- Pointers `wp` and `rp` are $clog2(DEP)+1 bits wide; the extra MSB distinguishes wrap.
  - `count = wp - rp`, computed modulo 2^(AW+1).
  - `empty = (count == 0)`; `full = (count == DEP)`.
  - Flags are registered and derived from the next-state pointers, so they are accurate in the same cycle the pointers update.
- Reset-busy sequencer has three states:
  - RESET: entered while `rst_n` is low. `wr_rst_busy` and `rd_rst_busy` are both 1.
  - WARM: entered when `rst_n` goes high. A counter loads `RST_BUSY-1` and counts down to 0. When it reaches 0, `wr_rst_busy` clears.
  - RUN: entered on the next cycle, when `rd_rst_busy` clears. RUN is held until the next reset.
- Write acceptance: `wa = wr && !wr_rst_busy && (!full || ra)`.
  - An accepted write stores `din` at `wp[AW-1:0]` and increments `wp`.
- Read acceptance: `ra = rd && !rd_rst_busy && !empty`.
  - An accepted read loads `dout` from `rp[AW-1:0]`, increments `rp`, and sets `valid` on the next cycle.
  - With no accepted read, `dout` holds its value and `valid` is 0.
- Simultaneous `rd` and `wr`:
  - When empty: the write is accepted, the read is dropped, and `underflow` pulses. Data is not bypassed.
  - When full: both are accepted and `count` is unchanged.
  - Otherwise: both are accepted and `count` is unchanged.
- `overflow` is set when `wr && !wr_rst_busy && !wa`.
- `underflow` is set when `rd && !rd_rst_busy && !ra`.
- Strobes during reset-busy are ignored silently; no flag pulses.
- Pointer wrap is natural modulo arithmetic; no special handling is needed at `DEP-1 -> 0`.

## Timing
- Reset values, applied on the clock edge where `rst_n` is 0:
  - `wp = rp = 0`, `count = 0`, `empty = 1`.
  - `full = almost_full = 0`.
  - `dout = 0`, `valid = 0`.
  - `overflow = underflow = 0`.
  - `wr_rst_busy = rd_rst_busy = 1`.
- With `rst_n` high from cycle 0:
  - `wr_rst_busy` falls at cycle `RST_BUSY`.
  - `rd_rst_busy` falls at cycle `RST_BUSY+1`.
- Reset mid-operation: all stored words are discarded and the sequence restarts from RESET. The memory array itself is not cleared.
- Write to empty flag: a write accepted in cycle n makes `empty` 0 at cycle n+1. A read may be issued in n+1, and its data is on `dout` with `valid` in n+2.
- Read latency is 1 cycle from `rd` to `dout`/`valid`.
- Flag latency is 1 cycle from the strobe edge.
- Throughput is one write and one read per cycle sustained.

## Structure
- `mpmc11_pkg` gains:
  - `MPMC11_FIFO_RST_BUSY = 8`;
  - the typedef `mpmc11_fifo_rst_state_t` (RESET, WARM, RUN).
- One sub-module, `mpmc11_fifo_ram`: a simple dual-port array with one write port and a registered read port, enabled by `ra`. It must infer as distributed or block RAM.
- The top level holds the pointers, flags, counter and sequencer.

## Test plan
- Reset release with `DEP=32`, `RST_BUSY=8`; `wr` held high from cycle 0 → no word is stored before cycle 8; `rd_rst_busy` = 0 at cycle 9; `overflow` never pulses.
- Write 0x1..0x20 back-to-back, then read 32 → `full` asserts after the 32nd write; `almost_full` asserts when count=28; data returns in order with 1-cycle latency; `empty` = 1 after the last read.
- When full, write 0xDEAD → `overflow` pulses once and `count` stays 32. Then `rd` and `wr` together → both are accepted, `count` stays 32, and 0xDEAD is absent from the output stream.
- When empty, `rd` and `wr` of 0x55 together → `underflow` pulses and `count` = 1. `rd` on the next cycle → `dout` = 0x55 with `valid` one cycle later.
- Wrap test: 100 random interleaved rd/wr cycles checked against a scoreboard → data order is preserved across pointer wrap, and `count` always equals the scoreboard depth.
- Drop `rst_n` for 1 cycle with 10 words stored → `empty` = 1, `count` = 0, both busy flags = 1, and the 8-cycle sequence repeats.
